// File: rtl/gc_pkg.sv
// gc_pkg: timing constants, FSM states and frame field positions shared by the
// GameCube controller poll generator and response receiver.
package gc_pkg;

    localparam int CLK_PER_US = 100;
    localparam int THRESH     = 2 * CLK_PER_US;
    localparam int TIMEOUT    = 5 * CLK_PER_US;
    localparam int FRAME_BITS = 64;

    // MSB index of each field within the 64-bit reply, first bit received = 63
    localparam int BUTTONS_MSB  = 63;
    localparam int STICK_X_MSB  = 47;
    localparam int STICK_Y_MSB  = 39;
    localparam int CSTICK_X_MSB = 31;
    localparam int CSTICK_Y_MSB = 23;
    localparam int TRIG_L_MSB   = 15;
    localparam int TRIG_R_MSB   = 7;

    typedef enum logic [2:0] {IDLE, ARMED, LOW, HIGH, HOLD} state_t;

endpackage

// File: rtl/gc_response_rx_if.sv
// gc_response_rx_if: response window control, data line and decoded reply fields.
interface gc_response_rx_if;

    logic        read;
    logic        data_in;
    logic [15:0] buttons;
    logic [7:0]  stick_x;
    logic [7:0]  stick_y;
    logic [7:0]  cstick_x;
    logic [7:0]  cstick_y;
    logic [7:0]  trig_l;
    logic [7:0]  trig_r;
    logic        frame_valid;
    logic        frame_error;

    modport master (
        output read, data_in,
        input  buttons, stick_x, stick_y, cstick_x, cstick_y, trig_l, trig_r,
        input  frame_valid, frame_error
    );

    modport slave (
        input  read, data_in,
        output buttons, stick_x, stick_y, cstick_x, cstick_y, trig_l, trig_r,
        output frame_valid, frame_error
    );

endinterface

// File: rtl/gc_line_sync.sv
// gc_line_sync: two-flop synchronizer plus history flop for the idle-high data line,
// producing the conditioned level and single-cycle fall/rise strobes.
module gc_line_sync (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic pin,
    output logic line,
    output logic fall,
    output logic rise
);

    logic [2:0] sh;

    always_ff @(posedge PCLK)
        sh <= !PRESETn ? 3'b111 : {sh[1:0], pin};

    assign line = sh[1];
    assign fall = sh[2] & ~sh[1];
    assign rise = ~sh[2] & sh[1];

endmodule

// File: rtl/gc_response_rx.sv
// gc_response_rx: times low pulses on the controller line during a response window
// and publishes a well-formed 64-bit reply as button, stick and trigger fields.
import gc_pkg::*;

module gc_response_rx #(
    parameter int CLK_PER_US = gc_pkg::CLK_PER_US,
    parameter int THRESH     = 2 * CLK_PER_US,
    parameter int TIMEOUT    = 5 * CLK_PER_US
) (
    input logic             PCLK,
    input logic             PRESETn,
    gc_response_rx_if.slave bus
);

    localparam logic [9:0] THR = 10'(THRESH);
    localparam logic [9:0] TO  = 10'(TIMEOUT);

    state_t      state, state_n;
    logic [9:0]  low_cnt, low_n, high_cnt, high_n;
    logic [6:0]  bits, bits_n;
    logic [63:0] frame, frame_n;
    logic        valid_n, error_n, line, fall, rise, bit_val;

    gc_line_sync u_sync (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .pin     (bus.data_in),
        .line    (line),
        .fall    (fall),
        .rise    (rise)
    );

    assign bit_val = low_cnt < THR;

    always_comb begin
        state_n = state;
        low_n   = low_cnt;
        high_n  = high_cnt;
        bits_n  = bits;
        frame_n = frame;
        valid_n = 1'b0;
        error_n = 1'b0;
        if (!bus.read && state != IDLE && state != HOLD) begin
            state_n = IDLE;
            error_n = bits != 7'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    low_n   = '0;
                    high_n  = '0;
                    bits_n  = '0;
                    state_n = bus.read ? ARMED : IDLE;
                end
                // high_cnt marks that the line was seen high in this window, so a
                // poll tail still low when the window opens cannot start a frame
                ARMED: begin
                    high_n = {9'd0, line};
                    if (fall && high_cnt != '0) begin
                        state_n = LOW;
                        low_n   = 10'd1;
                    end
                end
                LOW: begin
                    low_n = low_cnt == '1 ? low_cnt : low_cnt + 10'd1;
                    if (low_cnt >= TO) begin
                        error_n = 1'b1;
                        state_n = HOLD;
                    end else if (rise) begin
                        high_n = 10'd1;
                        if (bits == 7'd64) begin
                            valid_n = bit_val;
                            error_n = !bit_val;
                            state_n = HOLD;
                        end else begin
                            frame_n = {frame[62:0], bit_val};
                            bits_n  = bits + 7'd1;
                            state_n = HIGH;
                        end
                    end
                end
                HIGH: begin
                    high_n = high_cnt == '1 ? high_cnt : high_cnt + 10'd1;
                    if (high_cnt >= TO) begin
                        error_n = 1'b1;
                        state_n = HOLD;
                    end else if (fall) begin
                        low_n   = 10'd1;
                        state_n = LOW;
                    end
                end
                HOLD: state_n = bus.read ? HOLD : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state           <= IDLE;
            low_cnt         <= '0;
            high_cnt        <= '0;
            bits            <= '0;
            frame           <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_error <= 1'b0;
            bus.buttons     <= '0;
            bus.stick_x     <= '0;
            bus.stick_y     <= '0;
            bus.cstick_x    <= '0;
            bus.cstick_y    <= '0;
            bus.trig_l      <= '0;
            bus.trig_r      <= '0;
        end else begin
            state           <= state_n;
            low_cnt         <= low_n;
            high_cnt        <= high_n;
            bits            <= bits_n;
            frame           <= frame_n;
            bus.frame_valid <= valid_n;
            bus.frame_error <= error_n;
            if (valid_n) begin
                bus.buttons  <= frame[BUTTONS_MSB  -: 16];
                bus.stick_x  <= frame[STICK_X_MSB  -: 8];
                bus.stick_y  <= frame[STICK_Y_MSB  -: 8];
                bus.cstick_x <= frame[CSTICK_X_MSB -: 8];
                bus.cstick_y <= frame[CSTICK_Y_MSB -: 8];
                bus.trig_l   <= frame[TRIG_L_MSB   -: 8];
                bus.trig_r   <= frame[TRIG_R_MSB   -: 8];
            end
        end
    end

endmodule

// File: tb/tb_gc_response_rx.sv
// tb_gc_response_rx: drives timed low pulses on the line and compares published
// fields and strobes with a pulse-length decoding model.
module tb_gc_response_rx;

    localparam int THRESH_CYC = 200;

    logic clk = 1'b0;
    logic PRESETn = 1'b0;
    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;
    int   n_valid = 0, n_err = 0, n_both = 0;
    int   valid_cyc = 0, err_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    logic [63:0] last_pub = '0, exp = '0;

    gc_response_rx_if bus ();

    gc_response_rx dut (
        .PCLK    (clk),
        .PRESETn (PRESETn),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_valid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (bus.frame_error) begin
            n_err++;
            err_cyc = cyc;
        end
        if (bus.frame_valid && bus.frame_error) n_both++;
    end

    function automatic logic [63:0] fields();
        return {bus.buttons, bus.stick_x, bus.stick_y, bus.cstick_x, bus.cstick_y,
                bus.trig_l, bus.trig_r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_tests++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_valid = 0;
        n_err   = 0;
    endtask

    task automatic open_window();
        bus.data_in = 1'b1;
        bus.read    = 1'b1;
        cycles(6);
    endtask

    // mode 0: 100/300 lows in 400-cycle bits, 1: 199/200 lows, 2: random low and high lengths
    task automatic send_bits(input int n, input logic [63:0] pat, input int mode,
                             inout logic [63:0] model);
        for (int i = 0; i < n; i++) begin
            logic b;
            int lo, hi;
            b  = pat[63-i];
            lo = mode == 0 ? (b ? 100 : 300) : mode == 1 ? (b ? 199 : 200)
                                             : int'($urandom_range(470, 20));
            hi = mode == 2 ? int'($urandom_range(450, 30)) : 400 - lo;
            model = {model[62:0], lo < THRESH_CYC};
            bus.data_in = 1'b0;
            cycles(lo);
            bus.data_in = 1'b1;
            cycles(hi);
        end
    endtask

    task automatic run_frame(input logic [63:0] pat, input int mode, input int stop_low,
                             output logic [63:0] model);
        model = '0;
        clr();
        open_window();
        send_bits(64, pat, mode, model);
        bus.data_in = 1'b0;
        cycles(stop_low);
        bus.data_in = 1'b1;
        rise_cyc = cyc;
        cycles(10);
        bus.read = 1'b0;
        cycles(5);
    endtask

    task automatic check_good(input string tag, input logic [63:0] model);
        check({tag, "_valid_cnt"}, 64'(n_valid), 64'd1);
        check({tag, "_err_cnt"}, 64'(n_err), 64'd0);
        check({tag, "_latency"}, 64'(valid_cyc - rise_cyc), 64'd3);
        check({tag, "_fields"}, fields(), model);
        last_pub = model;
    endtask

    initial begin
        logic [63:0] pat;
        bus.read    = 1'b0;
        bus.data_in = 1'b1;
        cycles(3);
        PRESETn = 1'b1;
        cycles(2);
        check("reset_fields", fields(), 64'd0);
        check("reset_strobes", 64'(n_valid + n_err), 64'd0);

        run_frame(64'h0080_8080_8080_1A1A, 0, 100, exp);
        check_good("good", exp);
        check("good_buttons", 64'(bus.buttons), 64'h0080);
        check("good_stick", {48'd0, bus.stick_x, bus.stick_y}, 64'h8080);
        check("good_trig", {48'd0, bus.trig_l, bus.trig_r}, 64'h1A1A);

        for (int k = 0; k < 3; k++) begin
            run_frame({$urandom, $urandom}, 2, int'($urandom_range(150, 20)), exp);
            check_good("rand", exp);
        end

        for (int k = 0; k < 2; k++) begin
            pat = {$urandom, $urandom};
            run_frame(pat, 1, 199, exp);
            check_good("thresh", exp);
            check("thresh_buttons", 64'(bus.buttons), 64'(pat[63:48]));
        end

        // stuck-low line after 10 bits, then a full frame inside the same window
        exp = '0;
        clr();
        open_window();
        send_bits(10, {$urandom, $urandom}, 0, exp);
        bus.data_in = 1'b0;
        fall_cyc = cyc;
        cycles(600);
        bus.data_in = 1'b1;
        cycles(5);
        check("stuck_err_cnt", 64'(n_err), 64'd1);
        check("stuck_err_time", 64'(err_cyc - fall_cyc), 64'd503);
        check("stuck_valid_cnt", 64'(n_valid), 64'd0);
        check("stuck_fields", fields(), last_pub);
        send_bits(64, {$urandom, $urandom}, 0, exp);
        bus.data_in = 1'b0;
        cycles(100);
        bus.data_in = 1'b1;
        cycles(10);
        check("hold_strobes", 64'(n_valid + n_err), 64'd1);
        bus.read = 1'b0;
        cycles(5);

        clr();
        open_window();
        send_bits(32, {$urandom, $urandom}, 0, exp);
        bus.read = 1'b0;
        cycles(5);
        check("early_err_cnt", 64'(n_err), 64'd1);
        check("early_valid_cnt", 64'(n_valid), 64'd0);
        check("early_fields", fields(), last_pub);

        clr();
        bus.read = 1'b1;
        cycles(20);
        bus.read = 1'b0;
        cycles(5);
        check("empty_strobes", 64'(n_valid + n_err), 64'd0);

        run_frame({$urandom, $urandom}, 0, 300, exp);
        check("badstop_err_cnt", 64'(n_err), 64'd1);
        check("badstop_valid_cnt", 64'(n_valid), 64'd0);
        check("badstop_fields", fields(), last_pub);

        clr();
        open_window();
        send_bits(40, {$urandom, $urandom}, 0, exp);
        PRESETn = 1'b0;
        cycles(1);
        PRESETn = 1'b1;
        check("rst_fields", fields(), 64'd0);
        check("rst_strobes", {62'd0, bus.frame_valid, bus.frame_error}, 64'd0);
        bus.read = 1'b0;
        cycles(10);
        run_frame({$urandom, $urandom}, 0, 100, exp);
        check_good("after_rst", exp);

        check("no_overlap", 64'(n_both), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
